riscv_v_decode_seq: RTL and testbench
=====================================

# riscv_v_decode_seq

LMUL-aware vector decode sequencer with register scoreboard, sitting between the vector instruction field decoder and the vector register-file read stage. It accepts one vector instruction at a time and expands it into LMUL register-group micro-ops. Each micro-op carries per-element-group register addresses. A micro-op is issued only when its source and destination registers have no pending writeback. It generalises single-register decode to parametrised register count, maximum LMUL, and mask-op handling.

## Interface
- NUM_VREGS, 32, number of architectural vector registers (power of two)
- MAX_LMUL, 8, largest supported group size (power of two, ≤ NUM_VREGS)
- AW, $clog2(NUM_VREGS), register address width (derived; do not override)
- clk  in  1  clock; one clock; all state is rising-edge
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  kill in-flight sequence and clear the scoreboard
- instr_valid  in  1  decoded instruction present
- instr_ready  out  1  sequencer can accept an instruction
- instr_vs1, instr_vs2, instr_vd  in  AW each  base register numbers
- instr_uses_vs1, instr_uses_vs2  in  1 each  source is a vector register
- instr_writes_vd  in  1  instruction writes the vector RF
- instr_is_mask  in  1  mask-register op; always one micro-op regardless of LMUL
- instr_vlmul  in  3  vtype.vlmul encoding: 000=1, 001=2, 010=4, 011=8, 1xx fractional → 1, 100 reserved
- uop_valid  out  1  micro-op present
- uop_ready  in  1  downstream accepts
- uop_vs1, uop_vs2, uop_vd  out  AW each  base + uop_idx
- uop_idx  out  $clog2(MAX_LMUL)+1  group index
- uop_first, uop_last  out  1 each  first and last micro-op of the instruction
- uop_writes_vd  out  1  copy of instr_writes_vd
- wb_valid  in  1  vector RF writeback retiring
- wb_addr  in  AW  register being written back
- illegal  out  1  one-cycle pulse for an illegal instruction
- sb_busy  out  NUM_VREGS  scoreboard bits

## Operation
- FSM states are IDLE and SEQ.
- instr_ready = (state==IDLE) && !flush.
- IDLE, instr_valid&&instr_ready:
  - Decode LMUL. L = min(2^vlmul, MAX_LMUL) for vlmul ≤ 011; L = 1 for fractional or instr_is_mask.
  - Illegal when any of: vlmul==100; 2^vlmul > MAX_LMUL; or any used register (vs1 if uses_vs1, vs2 if uses_vs2, vd if writes_vd) is not a multiple of L.
  - Illegal: pulse illegal next cycle, stay IDLE, emit no micro-op.
  - Legal: latch the fields, set idx=0, go to SEQ.
- SEQ: micro-op idx has registers base+idx.
  - hazard = (uses_vs1 && busy[vs1+idx]) || (uses_vs2 && busy[vs2+idx]) || (writes_vd && busy[vd+idx]).
  - uop_valid = !hazard.
  - On uop_valid&&uop_ready: idx++. If idx==L-1, go to IDLE. If writes_vd, set busy[vd+idx].
  - Hold all uop outputs stable while uop_valid&&!uop_ready. uop_valid may deassert only if a hazard appears, which cannot happen while the micro-op is held.
- Scoreboard:
  - wb_valid clears busy[wb_addr].
  - A set and a clear to the same register in the same cycle: set wins.
  - wb to a non-busy register is ignored.
- flush:
  - FSM → IDLE, idx=0, all busy bits cleared, illegal cleared.
  - flush overrides all other events in that cycle.
  - An instruction offered during flush is not accepted.
- Address arithmetic is modulo NUM_VREGS. Alignment guarantees no wrap for legal instructions.

## Timing
- Reset values:
  - state=IDLE, so instr_ready=1.
  - uop_valid=0; all uop fields 0.
  - illegal=0.
  - sb_busy=0.
- Latency: instruction accepted in cycle N → first uop_valid in N+1 when hazard-free.
- Throughput: one micro-op per cycle with uop_ready=1. The next instruction is accepted the cycle after the last handshake, so there is one bubble per instruction.
- Hazard release without bypass: wb in cycle N clears busy at the N edge → the dependent micro-op is valid in N+1.

## Configuration
- RISCV_V_SB_BYPASS_EN defined:
  - The hazard check ignores busy[wb_addr] when wb_valid is high in the same cycle.
  - The dependent micro-op is valid in cycle N, the same cycle as the writeback.
- Undefined: no bypass, so release is one cycle later as described in Timing.
- Both builds are functionally correct. The macro only changes latency.

## Test plan
- vlmul=010, vs1=4, vs2=8, vd=12, writes_vd, uop_ready=1 → micro-ops in cycles N+1..N+4 with vd=12,13,14,15 and vs1=4..7. uop_first in cycle N+1, uop_last in cycle N+4. sb_busy[15:12]=1111.
- busy[5]=1, instruction reads vs1=5 at LMUL=1 → uop_valid=0 until wb_valid with wb_addr=5. Then valid next cycle without the macro, or same cycle with RISCV_V_SB_BYPASS_EN.
- vlmul=001 with vd=3 → illegal pulses one cycle, no uop_valid, instr_ready back to 1 the next cycle. vlmul=100 → same response.
- vlmul=011 sequence with uop_ready=0 held 3 cycles at idx=2 → uop_vd, uop_idx and uop_valid stable. Idx 3 is issued after ready returns.
- flush asserted after idx=1 of an LMUL=4 op → next cycle state IDLE, sb_busy=0, instr_ready=1, no further micro-ops.
- Issue writes vd=7 while wb_valid with wb_addr=7 in the same cycle → busy[7] remains 1.

Source files
------------

// File: rtl/riscv_v_decode_seq.sv
// riscv_v_decode_seq: LMUL-aware vector decode sequencer with register scoreboard.
// Takes one decoded vector instruction at a time and expands it into LMUL
// register-group micro-ops. Each micro-op issues only when none of its registers
// has a pending writeback.
// Optional feature: define RISCV_V_SB_BYPASS_EN so that a writeback arriving in
// the same cycle releases a hazard immediately instead of one cycle later.
module riscv_v_decode_seq #(
  parameter int unsigned NUM_VREGS = 32,
  parameter int unsigned MAX_LMUL  = 8,
  parameter int unsigned AW        = $clog2(NUM_VREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [AW-1:0]              instr_vs1,
  input  logic [AW-1:0]              instr_vs2,
  input  logic [AW-1:0]              instr_vd,
  input  logic                       instr_uses_vs1,
  input  logic                       instr_uses_vs2,
  input  logic                       instr_writes_vd,
  input  logic                       instr_is_mask,
  input  logic [2:0]                 instr_vlmul,
  output logic                       uop_valid,
  input  logic                       uop_ready,
  output logic [AW-1:0]              uop_vs1,
  output logic [AW-1:0]              uop_vs2,
  output logic [AW-1:0]              uop_vd,
  output logic [$clog2(MAX_LMUL):0]  uop_idx,
  output logic                       uop_first,
  output logic                       uop_last,
  output logic                       uop_writes_vd,
  input  logic                       wb_valid,
  input  logic [AW-1:0]              wb_addr,
  output logic                       illegal,
  output logic [NUM_VREGS-1:0]       sb_busy
);

  localparam int unsigned IW = $clog2(MAX_LMUL) + 1;

  typedef enum logic {IDLE, SEQ} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        last_q;
  logic [AW-1:0]        vs1_q, vs2_q, vd_q;
  logic                 uses1_q, uses2_q, wvd_q;
  logic                 illegal_q;
  logic [NUM_VREGS-1:0] busy_q, busy_d, busy_eff;

  logic [3:0]           dec_pow, dec_len;
  logic [AW-1:0]        dec_mask;
  logic                 dec_too_big, dec_misal, dec_illegal;
  logic [AW-1:0]        idx_a, a1, a2, ad;
  logic                 hazard, in_seq, accept, fire;

  // Group-size decode and legality of the offered instruction
  always_comb begin
    dec_pow     = 4'd1 << instr_vlmul[1:0];
    dec_len     = (instr_is_mask || instr_vlmul[2]) ? 4'd1 : dec_pow;
    dec_mask    = AW'(dec_len - 4'd1);
    dec_too_big = !instr_vlmul[2] && (32'(dec_pow) > MAX_LMUL);
    dec_misal   = (instr_uses_vs1  && |(instr_vs1 & dec_mask)) ||
                  (instr_uses_vs2  && |(instr_vs2 & dec_mask)) ||
                  (instr_writes_vd && |(instr_vd  & dec_mask));
    dec_illegal = (instr_vlmul == 3'b100) || dec_too_big || dec_misal;
  end

  // Current micro-op register addresses and hazard check against the scoreboard
  always_comb begin
    idx_a    = AW'(idx_q);
    a1       = vs1_q + idx_a;
    a2       = vs2_q + idx_a;
    ad       = vd_q + idx_a;
    busy_eff = busy_q;
`ifdef RISCV_V_SB_BYPASS_EN
    if (wb_valid) busy_eff[wb_addr] = 1'b0;
`endif
    hazard   = (uses1_q && busy_eff[a1]) ||
               (uses2_q && busy_eff[a2]) ||
               (wvd_q   && busy_eff[ad]);
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    in_seq        = (state_q == SEQ);
    instr_ready   = (state_q == IDLE) && !flush;
    accept        = instr_valid && instr_ready;
    uop_valid     = in_seq && !hazard;
    fire          = uop_valid && uop_ready;
    uop_vs1       = in_seq ? a1 : '0;
    uop_vs2       = in_seq ? a2 : '0;
    uop_vd        = in_seq ? ad : '0;
    uop_idx       = in_seq ? idx_q : '0;
    uop_first     = in_seq && (idx_q == '0);
    uop_last      = in_seq && (idx_q == last_q);
    uop_writes_vd = in_seq && wvd_q;
    illegal       = illegal_q;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && !dec_illegal) begin
            state_d = SEQ;
            idx_d   = '0;
          end
        end
        SEQ: begin
          if (fire) begin
            if (idx_q == last_q) begin
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Scoreboard update: writeback clears, issue sets (set applied last so it wins)
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (fire && wvd_q) busy_d[ad] = 1'b1;
    if (flush) busy_d = '0;
  end

  assign sb_busy = busy_q;

  // State, scoreboard and illegal-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      illegal_q <= accept && dec_illegal;
    end
  end

  // Latch the instruction fields when a legal instruction is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      uses1_q <= 1'b0;
      uses2_q <= 1'b0;
      wvd_q   <= 1'b0;
      last_q  <= '0;
    end else if (accept && !dec_illegal) begin
      vs1_q   <= instr_vs1;
      vs2_q   <= instr_vs2;
      vd_q    <= instr_vd;
      uses1_q <= instr_uses_vs1;
      uses2_q <= instr_uses_vs2;
      wvd_q   <= instr_writes_vd;
      last_q  <= IW'(dec_len - 4'd1);
    end
  end

endmodule

// File: tb/tb_riscv_v_decode_seq.sv
// Directed self-checking bench for riscv_v_decode_seq (default parameters).
module tb_riscv_v_decode_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  instr_vs1, instr_vs2, instr_vd;
  logic        instr_uses_vs1, instr_uses_vs2, instr_writes_vd, instr_is_mask;
  logic [2:0]  instr_vlmul;
  logic        uop_valid, uop_ready;
  logic [4:0]  uop_vs1, uop_vs2, uop_vd;
  logic [3:0]  uop_idx;
  logic        uop_first, uop_last, uop_writes_vd;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        illegal;
  logic [31:0] sb_busy;

  int checks = 0;
  int errors = 0;

  riscv_v_decode_seq #(.NUM_VREGS(32), .MAX_LMUL(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_vs1(instr_vs1), .instr_vs2(instr_vs2), .instr_vd(instr_vd),
    .instr_uses_vs1(instr_uses_vs1), .instr_uses_vs2(instr_uses_vs2),
    .instr_writes_vd(instr_writes_vd), .instr_is_mask(instr_is_mask),
    .instr_vlmul(instr_vlmul),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_vs1(uop_vs1), .uop_vs2(uop_vs2), .uop_vd(uop_vd),
    .uop_idx(uop_idx), .uop_first(uop_first), .uop_last(uop_last),
    .uop_writes_vd(uop_writes_vd),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .illegal(illegal), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  vlmul;
    logic [4:0]  vs1, vs2, vd;
    logic        u1, u2, w, m;
    logic        ill;
    int          n;
    logic [31:0] busy;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic set_instr(input logic [2:0] vl, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d, input logic u1, input logic u2,
                           input logic w, input logic m);
    instr_vlmul     = vl;
    instr_vs1       = s1;
    instr_vs2       = s2;
    instr_vd        = d;
    instr_uses_vs1  = u1;
    instr_uses_vs2  = u2;
    instr_writes_vd = w;
    instr_is_mask   = m;
    instr_valid     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, ill, first_c, cnt;
    logic        done;
    logic [4:0]  e;

    //            vlmul   vs1    vs2    vd     u1 u2 w  m  ill n  busy
    vecs[0] = '{3'b010, 5'd4,  5'd8,  5'd12, 1, 1, 1, 0, 0, 4, 32'h0000_F000};
    vecs[1] = '{3'b001, 5'd0,  5'd0,  5'd3,  0, 0, 1, 0, 1, 0, 32'h0000_0000};
    vecs[2] = '{3'b100, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 1, 0, 32'h0000_0000};
    vecs[3] = '{3'b011, 5'd0,  5'd16, 5'd8,  0, 1, 1, 0, 0, 8, 32'h0000_FF00};
    vecs[4] = '{3'b000, 5'd3,  5'd0,  5'd7,  1, 0, 1, 0, 0, 1, 32'h0000_0080};
    vecs[5] = '{3'b011, 5'd5,  5'd0,  5'd3,  1, 0, 1, 1, 0, 1, 32'h0000_0008};
    vecs[6] = '{3'b111, 5'd0,  5'd0,  5'd5,  0, 0, 1, 0, 0, 1, 32'h0000_0020};
    vecs[7] = '{3'b010, 5'd6,  5'd0,  5'd4,  0, 0, 1, 0, 0, 4, 32'h0000_00F0};
    vecs[8] = '{3'b010, 5'd0,  5'd2,  5'd4,  0, 1, 0, 0, 1, 0, 32'h0000_0000};
    vecs[9] = '{3'b001, 5'd2,  5'd0,  5'd0,  1, 0, 0, 0, 0, 2, 32'h0000_0000};

    rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; uop_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = '0;
    set_instr(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_uop_valid", uop_valid, 0);
    chk("rst_uop_vd", uop_vd, 0);
    chk("rst_uop_idx", uop_idx, 0);
    chk("rst_uop_first", uop_first, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_sb_busy", sb_busy, 0);

    // Table-driven single-instruction vectors
    for (int i = 0; i < NV; i++) begin
      do_flush();
      set_instr(vecs[i].vlmul, vecs[i].vs1, vecs[i].vs2, vecs[i].vd,
                vecs[i].u1, vecs[i].u2, vecs[i].w, vecs[i].m);
      uop_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", i), instr_ready, 1);
      tick();
      instr_valid = 1'b0;
      #1;
      n = 0; ill = 0; first_c = -1; done = 1'b0;
      for (int c = 0; c < 12 && !done; c++) begin
        if (illegal) ill++;
        if (uop_valid) begin
          if (n == 0) first_c = c;
          e = vecs[i].vd + 5'(n);
          chk($sformatf("v%0d_u%0d_vd", i, n), uop_vd, e);
          e = vecs[i].vs1 + 5'(n);
          chk($sformatf("v%0d_u%0d_vs1", i, n), uop_vs1, e);
          e = vecs[i].vs2 + 5'(n);
          chk($sformatf("v%0d_u%0d_vs2", i, n), uop_vs2, e);
          chk($sformatf("v%0d_u%0d_idx", i, n), uop_idx, n);
          chk($sformatf("v%0d_u%0d_first", i, n), uop_first, n == 0);
          chk($sformatf("v%0d_u%0d_last", i, n), uop_last, n == vecs[i].n - 1);
          chk($sformatf("v%0d_u%0d_wvd", i, n), uop_writes_vd, vecs[i].w);
          n++;
          if (uop_last) done = 1'b1;
        end
        tick();
        #1;
      end
      chk($sformatf("v%0d_illegal_pulses", i), ill, vecs[i].ill ? 1 : 0);
      chk($sformatf("v%0d_uop_count", i), n, vecs[i].n);
      if (!vecs[i].ill) chk($sformatf("v%0d_first_latency", i), first_c, 0);
      chk($sformatf("v%0d_sb_busy", i), sb_busy, vecs[i].busy);
      chk($sformatf("v%0d_ready_after", i), instr_ready, 1);
    end

    // Hazard on vs1 released by writeback
    do_flush();
    set_instr(3'b000, 5'd0, 5'd0, 5'd5, 0, 0, 1, 0);
    tick();
    instr_valid = 1'b0;
    #1;
    chk("haz_producer_valid", uop_valid, 1);
    tick();
    set_instr(3'b000, 5'd5, 5'd0, 5'd9, 1, 0, 1, 0);
    #1;
    chk("haz_busy5", sb_busy, 32'h0000_0020);
    tick();
    instr_valid = 1'b0;
    #1;
    chk("haz_stall0", uop_valid, 0);
    for (int k = 1; k < 3; k++) begin
      tick();
      #1;
      chk($sformatf("haz_stall%0d", k), uop_valid, 0);
    end
    tick();
    wb_valid = 1'b1; wb_addr = 5'd5;
    #1;
`ifdef RISCV_V_SB_BYPASS_EN
    chk("haz_wb_cycle_valid", uop_valid, 1);
`else
    chk("haz_wb_cycle_valid", uop_valid, 0);
`endif
    tick();
    wb_valid = 1'b0;
    #1;
`ifdef RISCV_V_SB_BYPASS_EN
    chk("haz_after_wb_valid", uop_valid, 0);
    chk("haz_after_wb_busy", sb_busy, 32'h0000_0200);
`else
    chk("haz_after_wb_valid", uop_valid, 1);
    chk("haz_after_wb_vd", uop_vd, 9);
    chk("haz_after_wb_busy", sb_busy, 32'h0000_0000);
`endif
    tick();
    #1;
    chk("haz_final_busy", sb_busy, 32'h0000_0200);
    chk("haz_final_ready", instr_ready, 1);

    // Backpressure at idx 2 of an LMUL=8 sequence
    do_flush();
    set_instr(3'b011, 5'd0, 5'd0, 5'd16, 0, 0, 1, 0);
    tick();
    instr_valid = 1'b0;
    #1;
    tick();
    #1;
    tick();
    uop_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        tick();
        #1;
      end
      chk($sformatf("stall%0d_valid", k), uop_valid, 1);
      chk($sformatf("stall%0d_idx", k), uop_idx, 2);
      chk($sformatf("stall%0d_vd", k), uop_vd, 18);
    end
    tick();
    uop_ready = 1'b1;
    #1;
    chk("stall_release_idx", uop_idx, 2);
    tick();
    #1;
    chk("stall_next_idx", uop_idx, 3);
    chk("stall_next_vd", uop_vd, 19);
    done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      if (uop_valid && uop_last) done = 1'b1;
      tick();
      #1;
    end
    chk("stall_drained", done, 1);
    chk("stall_busy", sb_busy, 32'h00FF_0000);

    // Flush in the middle of an LMUL=4 sequence, with an instruction offered
    do_flush();
    set_instr(3'b010, 5'd0, 5'd0, 5'd20, 0, 0, 1, 0);
    tick();
    instr_valid = 1'b0;
    #1;
    chk("fl_idx0", uop_idx, 0);
    tick();
    #1;
    chk("fl_idx1", uop_idx, 1);
    tick();
    flush = 1'b1;
    set_instr(3'b000, 5'd0, 5'd0, 5'd1, 0, 0, 1, 0);
    #1;
    chk("fl_ready_during", instr_ready, 0);
    chk("fl_busy_before", sb_busy, 32'h0030_0000);
    tick();
    flush = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("fl_uop_valid", uop_valid, 0);
    chk("fl_busy", sb_busy, 0);
    chk("fl_ready", instr_ready, 1);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      if (uop_valid) cnt++;
    end
    chk("fl_no_uops", cnt, 0);

    // Set and clear of the same register in one cycle, and stray writebacks
    do_flush();
    set_instr(3'b000, 5'd0, 5'd0, 5'd7, 0, 0, 1, 0);
    tick();
    instr_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd7;
    #1;
    chk("sw_uop_valid", uop_valid, 1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("sw_set_wins", sb_busy, 32'h0000_0080);
    wb_valid = 1'b1; wb_addr = 5'd3;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("sw_stray_wb", sb_busy, 32'h0000_0080);
    wb_valid = 1'b1; wb_addr = 5'd7;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("sw_clear", sb_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
